// File: rtl/fci_host_if.sv
// FCI byte bus between the CPLD (slave) and the FPGA (master).
interface fci_host_if;
   logic [1:0] fci_sel;
   logic       fci_dir;
   logic [7:0] fci_in;
   logic [7:0] fci_out;
   logic       fci_oe;

   modport master (output fci_sel, fci_dir, fci_in, input  fci_out, fci_oe);
   modport slave  (input  fci_sel, fci_dir, fci_in, output fci_out, fci_oe);
endinterface

// File: rtl/fci_host.sv
// CPLD end of the FCI link: latches ZX-BUS cycles, serves them to the FPGA
// byte by byte and stalls CPU reads until the FPGA answers or the timer expires.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | waiting for a new (non-INTA) CPU cycle
// S_WR_HOLD  | write latched, held for the FPGA until WR is released
// S_RD_WAIT  | CPU held in WAIT until FPGA returns data or timer expires
// S_RD_DRIVE | WAIT released, data driven to the CPU if one was captured
// S_END      | waiting for every strobe to go low before re-arming
module fci_host #(
   parameter int TIMEOUT = 32,
   parameter bit WAIT_EN = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] z_addr,
   input  logic [7:0]  z_data_in,
   input  logic        z_rd,
   input  logic        z_wr,
   input  logic        z_mrq,
   input  logic        z_iorq,
   input  logic        z_m1,
   output logic [7:0]  z_data_out,
   output logic        z_data_oe,
   output logic        z_wait_n,
   output logic        busy,
   fci_host_if.slave   fci
);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_HOLD, S_RD_WAIT, S_RD_DRIVE, S_END
   } state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [4:0]  sync_a, sync_b;
   logic [1:0]  vld_sr;
   logic        armed, start_q, start_raw, start;
   logic        s_rd, s_wr, s_mrq, s_iorq, s_m1;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic [3:0]  kind;
   logic        m1_lat;
   logic [7:0]  timer;
   logic        data_vld, data_vld_nxt;
   logic        capture, timeout_hit, strobes_idle;

   assign {s_rd, s_wr, s_mrq, s_iorq, s_m1} = sync_b;

   assign start_raw    = (s_rd | s_wr) & (s_mrq | s_iorq) & ~(s_iorq & s_m1);
   assign start        = start_raw & ~start_q & armed;
   assign strobes_idle = ~(s_rd | s_wr | s_mrq | s_iorq);
   assign capture      = ~fci.fci_dir & (fci.fci_sel == 2'b10);
   assign timeout_hit  = (timer == TIMEOUT_LAST);
   assign busy         = (state != S_IDLE);
   assign fci.fci_oe   = fci.fci_dir;

   // armed only goes high once a real (post-reset) sample shows no cycle,
   // so a strobe still held across reset cannot start a cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_a  <= '0;
         sync_b  <= '0;
         vld_sr  <= '0;
         start_q <= 1'b0;
         armed   <= 1'b0;
      end else begin
         sync_a  <= {z_rd, z_wr, z_mrq, z_iorq, z_m1};
         sync_b  <= sync_a;
         vld_sr  <= {vld_sr[0], 1'b1};
         start_q <= start_raw;
         armed   <= armed | (vld_sr[1] & ~start_raw);
      end
   end

   always_comb begin
      state_nxt    = state;
      data_vld_nxt = data_vld;
      case (state)
         S_IDLE: begin
            if (start) begin
               data_vld_nxt = 1'b0;
               state_nxt    = s_rd ? S_RD_WAIT : S_WR_HOLD;
            end
         end
         S_WR_HOLD:  if (!s_wr) state_nxt = S_END;
         S_RD_WAIT: begin
            if (!s_rd) begin
               state_nxt = S_END;
            end else if (capture) begin
               state_nxt    = S_RD_DRIVE;
               data_vld_nxt = 1'b1;
            end else if (timeout_hit) begin
               state_nxt = S_RD_DRIVE;
            end
         end
         S_RD_DRIVE: if (!s_rd) state_nxt = S_END;
         S_END:      if (strobes_idle) state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         data_vld    <= 1'b0;
         addr        <= '0;
         wdata       <= '0;
         kind        <= '0;
         m1_lat      <= 1'b0;
         timer       <= '0;
         z_data_out  <= '0;
         z_data_oe   <= 1'b0;
         z_wait_n    <= 1'b1;
         fci.fci_out <= '0;
      end else begin
         state    <= state_nxt;
         data_vld <= data_vld_nxt;
         if (state == S_IDLE && start) begin
            addr   <= z_addr;
            wdata  <= z_data_in;
            kind   <= {s_rd, s_wr, s_mrq, s_iorq};
            m1_lat <= s_m1;
         end
         if (state == S_RD_WAIT && s_rd && capture)
            z_data_out <= fci.fci_in;
         if (state != S_RD_WAIT)
            timer <= '0;
         else if (timer != 8'hff)
            timer <= timer + 8'd1;
         // Outputs follow the next state so they change on the transition edge.
         z_data_oe <= (state_nxt == S_RD_DRIVE) & data_vld_nxt;
         z_wait_n  <= ~(WAIT_EN & (state_nxt == S_RD_WAIT));
         case (fci.fci_sel)
            2'b00:   fci.fci_out <= addr[7:0];
            2'b01:   fci.fci_out <= addr[15:8];
            2'b10:   fci.fci_out <= wdata;
            default: fci.fci_out <= {kind, m1_lat, 3'b000};
         endcase
      end
   end

endmodule

// File: tb/tb_fci_host.sv
// Directed bench for fci_host: write, read with response, timeout, INTA,
// reset mid-read and capture/timeout collision.
module tb_fci_host;
   localparam int TMO = 32;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] z_addr;
   logic [7:0]  z_data_in;
   logic        z_rd, z_wr, z_mrq, z_iorq, z_m1;
   logic [7:0]  z_data_out;
   logic        z_data_oe, z_wait_n, busy;
   int          tests = 0;
   int          fails = 0;
   int          low_cnt;
   logic        oe_seen;

   fci_host_if fci ();

   fci_host #(.TIMEOUT(TMO), .WAIT_EN(1'b1)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .z_addr     (z_addr),
      .z_data_in  (z_data_in),
      .z_rd       (z_rd),
      .z_wr       (z_wr),
      .z_mrq      (z_mrq),
      .z_iorq     (z_iorq),
      .z_m1       (z_m1),
      .z_data_out (z_data_out),
      .z_data_oe  (z_data_oe),
      .z_wait_n   (z_wait_n),
      .busy       (busy),
      .fci        (fci)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      z_addr = 16'h0000; z_data_in = 8'h00;
      z_rd = 0; z_wr = 0; z_mrq = 0; z_iorq = 0; z_m1 = 0;
      fci.fci_sel = 2'b00; fci.fci_dir = 1'b1; fci.fci_in = 8'h00;
      tick(3);
      check8("rst_data_out", z_data_out, 8'h00);
      check1("rst_data_oe", z_data_oe, 1'b0);
      check1("rst_wait_n", z_wait_n, 1'b1);
      check1("rst_busy", busy, 1'b0);
      check8("rst_fci_out", fci.fci_out, 8'h00);
      check1("rst_fci_oe", fci.fci_oe, 1'b1);
      reset_n = 1'b1;
      tick(4);

      // IO write at 0xFB5A, data 0x3C
      z_addr = 16'hFB5A; z_data_in = 8'h3C; z_iorq = 1; z_wr = 1;
      tick(2);
      check1("wr_busy_early", busy, 1'b0);
      tick(1);
      check1("wr_busy_start", busy, 1'b1);
      check1("wr_wait_n", z_wait_n, 1'b1);
      fci.fci_sel = 2'b00; tick(1); check8("wr_sel00", fci.fci_out, 8'h5A);
      fci.fci_sel = 2'b01; tick(1); check8("wr_sel01", fci.fci_out, 8'hFB);
      fci.fci_sel = 2'b10; tick(1); check8("wr_sel10", fci.fci_out, 8'h3C);
      fci.fci_sel = 2'b11; tick(1); check8("wr_sel11", fci.fci_out, 8'h50);
      check1("wr_wait_n_hold", z_wait_n, 1'b1);
      z_wr = 0; z_iorq = 0;
      tick(3);
      check1("wr_busy_end", busy, 1'b1);
      tick(1);
      check1("wr_idle", busy, 1'b0);

      // Memory read at 0x4000 answered with 0xA5
      z_addr = 16'h4000; z_mrq = 1; z_rd = 1;
      tick(3);
      check1("rd_busy", busy, 1'b1);
      check1("rd_wait_low", z_wait_n, 1'b0);
      fci.fci_sel = 2'b11; tick(1);
      check8("rd_status", fci.fci_out, 8'hA0);
      check1("rd_oe_before", z_data_oe, 1'b0);
      fci.fci_dir = 1'b0; fci.fci_sel = 2'b10; fci.fci_in = 8'hA5;
      check1("rd_fci_oe_off", fci.fci_oe, 1'b0);
      tick(1);
      check8("rd_data", z_data_out, 8'hA5);
      check1("rd_oe", z_data_oe, 1'b1);
      check1("rd_wait_high", z_wait_n, 1'b1);
      fci.fci_dir = 1'b1; fci.fci_sel = 2'b00;
      z_rd = 0; z_mrq = 0;
      tick(2);
      check1("rd_oe_hold", z_data_oe, 1'b1);
      tick(1);
      check1("rd_oe_drop", z_data_oe, 1'b0);
      tick(1);
      check1("rd_idle", busy, 1'b0);

      // Read with FPGA silent: WAIT low for exactly TMO clocks
      z_addr = 16'h1234; z_mrq = 1; z_rd = 1;
      tick(3);
      check1("to_wait_low", z_wait_n, 1'b0);
      low_cnt = 1; oe_seen = 1'b0;
      for (int i = 0; i < TMO + 8; i++) begin
         tick(1);
         if (z_data_oe) oe_seen = 1'b1;
         if (z_wait_n) break;
         low_cnt++;
      end
      check8("to_low_clocks", 8'(low_cnt), 8'(TMO));
      check1("to_wait_high", z_wait_n, 1'b1);
      check1("to_oe_never", oe_seen, 1'b0);
      z_rd = 0; z_mrq = 0;
      tick(5);
      check1("to_idle", busy, 1'b0);

      // Interrupt acknowledge must be ignored
      fci.fci_sel = 2'b11;
      z_iorq = 1; z_m1 = 1; z_rd = 1;
      tick(6);
      check1("inta_busy", busy, 1'b0);
      check1("inta_wait_n", z_wait_n, 1'b1);
      check8("inta_status", fci.fci_out, 8'hA0);
      z_iorq = 0; z_m1 = 0; z_rd = 0;
      tick(4);

      // Reset in the middle of a read
      z_addr = 16'h8001; z_mrq = 1; z_rd = 1;
      tick(3);
      check1("rr_wait_low", z_wait_n, 1'b0);
      #1 reset_n = 1'b0;
      #1;
      check1("rr_wait_n", z_wait_n, 1'b1);
      check1("rr_busy", busy, 1'b0);
      check1("rr_oe", z_data_oe, 1'b0);
      check8("rr_data_out", z_data_out, 8'h00);
      check8("rr_fci_out", fci.fci_out, 8'h00);
      tick(2);
      reset_n = 1'b1;
      tick(8);
      check1("rr_no_restart", busy, 1'b0);
      z_rd = 0;
      tick(4);
      check1("rr_still_idle", busy, 1'b0);
      z_rd = 1;
      tick(3);
      check1("rr_restart", busy, 1'b1);
      check1("rr_restart_wait", z_wait_n, 1'b0);

      // Capture in the very clock the timer expires: data wins
      tick(TMO - 1);
      check1("col_wait_low", z_wait_n, 1'b0);
      fci.fci_dir = 1'b0; fci.fci_sel = 2'b10; fci.fci_in = 8'h5C;
      tick(1);
      check8("col_data", z_data_out, 8'h5C);
      check1("col_oe", z_data_oe, 1'b1);
      check1("col_wait_high", z_wait_n, 1'b1);
      fci.fci_dir = 1'b1;
      z_rd = 0; z_mrq = 0;
      tick(5);
      check1("col_oe_off", z_data_oe, 1'b0);
      check1("col_idle", busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
